// File: rtl/lottery_input_ctrl.sv
// lottery_input_ctrl
//   Input conditioner in front of the lottery game FSM. Synchronises and
//   debounces the insert/finish pushbuttons and the digit switches. It emits
//   clean one-cycle insert/finish pulses and a held digit value. Out-of-range
//   digits and premature finish requests never reach the game.
// Ports
//   clk             rising-edge system clock
//   reset           asynchronous active-low reset
//   btn_insert_raw  raw insert button (async, bouncy)
//   btn_finish_raw  raw finish button (async, bouncy)
//   sw_num[3:0]     raw digit switches (async)
//   num[3:0]        last accepted digit
//   insert          one-cycle pulse: digit on num accepted
//   finish          one-cycle pulse: game complete
//   digit_err       sticky: last insert attempt was out of range
//   digit_count     digits accepted in the current game
module lottery_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned MAX_DIGIT       = 9,
    parameter int unsigned NUM_DIGITS      = 5,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_insert_raw,
    input  logic       btn_finish_raw,
    input  logic [3:0] sw_num,
    output logic [3:0] num,
    output logic       insert,
    output logic       finish,
    output logic       digit_err,
    output logic [2:0] digit_count
);

    localparam int unsigned CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] MAX_D    = 4'(MAX_DIGIT);
    localparam logic [2:0] NUM_D    = 3'(NUM_DIGITS);

    typedef enum logic {
        COLLECT,
        READY
    } state_t;

    // Bit 0 = insert, bit 1 = finish; 1 means pressed regardless of board polarity.
    logic [1:0]    raw_pressed;
    logic [1:0]    btn_s1, btn_s2;
    logic [1:0]    db, db_q, ev;
    logic [CW-1:0] cnt [2];
    logic [3:0]    sw_s1, sw_s;

    assign raw_pressed = BTN_ACTIVE_LOW ? ~{btn_finish_raw, btn_insert_raw}
                                        :  {btn_finish_raw, btn_insert_raw};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s   <= '0;
            db     <= '0;
            db_q   <= '0;
            ev     <= '0;
            for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            btn_s1 <= raw_pressed;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_num;
            sw_s   <= sw_s1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (btn_s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= btn_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            db_q <= db;
            // Press event only on released->pressed; releases are ignored.
            ev   <= db & ~db_q;
        end
    end

    state_t     state_q, state_d;
    logic [3:0] num_d;
    logic       insert_d, finish_d, err_d;
    logic [2:0] count_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COLLECT;
            num         <= '0;
            insert      <= 1'b0;
            finish      <= 1'b0;
            digit_err   <= 1'b0;
            digit_count <= '0;
        end else begin
            state_q     <= state_d;
            num         <= num_d;
            insert      <= insert_d;
            finish      <= finish_d;
            digit_err   <= err_d;
            digit_count <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        num_d    = num;
        insert_d = 1'b0;
        finish_d = 1'b0;
        err_d    = digit_err;
        count_d  = digit_count;
        case (state_q)
            COLLECT: begin
                // A finish event here is dropped, including when it coincides with insert.
                if (ev[0]) begin
                    if (sw_s <= MAX_D) begin
                        num_d    = sw_s;
                        insert_d = 1'b1;
                        count_d  = digit_count + 3'd1;
                        err_d    = 1'b0;
                        if (count_d == NUM_D) state_d = READY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READY: begin
                // A simultaneous insert wins (and is ignored), so finish is dropped.
                if (ev[1] && !ev[0]) begin
                    finish_d = 1'b1;
                    count_d  = '0;
                    err_d    = 1'b0;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_lottery_input_ctrl.sv
module tb_lottery_input_ctrl;

    localparam int DB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_insert_raw, btn_finish_raw;
    logic [3:0] sw_num;
    logic [3:0] num;
    logic       insert, finish, digit_err;
    logic [2:0] digit_count;

    lottery_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_DIGIT(9),
        .NUM_DIGITS(5),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_insert_raw(btn_insert_raw),
        .btn_finish_raw(btn_finish_raw),
        .sw_num(sw_num),
        .num(num),
        .insert(insert),
        .finish(finish),
        .digit_err(digit_err),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ins_cnt = 0;
    int fin_cnt = 0;
    bit both_high = 1'b0;
    bit nonzero_seen = 1'b0;

    // Pulse monitor: counts high cycles of insert/finish, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (insert) ins_cnt++;
        if (finish) fin_cnt++;
        if (insert && finish) both_high = 1'b1;
        if (insert || finish || digit_err || num != 4'd0 || digit_count != 3'd0)
            nonzero_seen = 1'b1;
    end

    typedef struct {
        logic       ins;
        logic       fin;
        logic [3:0] sw;
        int         exp_ins;
        int         exp_fin;
        int         exp_num;
        int         exp_err;
        int         exp_cnt;
    } vec_t;

    function automatic vec_t mk(logic i, logic f, logic [3:0] s,
                                int ei, int ef, int en, int ee, int ec);
        vec_t v;
        v.ins = i; v.fin = f; v.sw = s;
        v.exp_ins = ei; v.exp_fin = ef; v.exp_num = en; v.exp_err = ee; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Clean press of the selected buttons with sw held, then full release.
    task automatic press(logic ins, logic fin, logic [3:0] sw);
        @(negedge clk);
        sw_num = sw;
        repeat (4) @(negedge clk);
        ins_cnt = 0;
        fin_cnt = 0;
        if (ins) btn_insert_raw = 1'b0;
        if (fin) btn_finish_raw = 1'b0;
        repeat (DB + 10) @(negedge clk);
        btn_insert_raw = 1'b1;
        btn_finish_raw = 1'b1;
        repeat (DB + 10) @(negedge clk);
    endtask

    vec_t vt[15];

    initial begin
        int n;
        bit seen;

        // Continues from state after T2/T3: num=5, count=1, err=0.
        vt[0]  = mk(1, 0, 4'd12, 0, 0, 5, 1, 1);
        vt[1]  = mk(1, 0, 4'd0,  1, 0, 0, 0, 2);
        vt[2]  = mk(1, 0, 4'd9,  1, 0, 9, 0, 3);
        vt[3]  = mk(0, 1, 4'd9,  0, 0, 9, 0, 3);  // finish after 3rd digit: ignored
        vt[4]  = mk(1, 0, 4'd15, 0, 0, 9, 1, 3);
        vt[5]  = mk(1, 0, 4'd6,  1, 0, 6, 0, 4);
        vt[6]  = mk(1, 0, 4'd7,  1, 0, 7, 0, 5);
        vt[7]  = mk(1, 0, 4'd3,  0, 0, 7, 0, 5);  // 6th insert in READY
        vt[8]  = mk(1, 0, 4'd12, 0, 0, 7, 0, 5);  // bad digit in READY: err unchanged
        vt[9]  = mk(1, 1, 4'd2,  0, 0, 7, 0, 5);  // both in READY
        vt[10] = mk(0, 1, 4'd2,  0, 1, 7, 0, 0);
        vt[11] = mk(1, 1, 4'd4,  1, 0, 4, 0, 1);  // both in COLLECT
        vt[12] = mk(1, 0, 4'd13, 0, 0, 4, 1, 1);
        vt[13] = mk(0, 1, 4'd13, 0, 0, 4, 1, 1);  // finish in COLLECT leaves err
        vt[14] = mk(1, 0, 4'd8,  1, 0, 8, 0, 2);

        reset = 1'b0;
        btn_insert_raw = 1'b1;
        btn_finish_raw = 1'b1;
        sw_num = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_num", num, 0);
        chk("reset_pulses", {insert, finish}, 0);
        chk("reset_err", digit_err, 0);
        chk("reset_count", digit_count, 0);

        // T1: idle after reset release
        reset = 1'b1;
        nonzero_seen = 1'b0;
        repeat (100) @(negedge clk);
        chk("t1_idle_outputs", nonzero_seen, 0);

        // T2: bouncy press of digit 5, latency from the final steady press
        sw_num = 4'd5;
        repeat (4) @(negedge clk);
        ins_cnt = 0;
        for (int b = 0; b < 3; b++) begin
            btn_insert_raw = 1'b0;
            repeat (5) @(negedge clk);
            btn_insert_raw = 1'b1;
            repeat (5) @(negedge clk);
        end
        btn_insert_raw = 1'b0;
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (insert) seen = 1'b1;
        end
        chk("t2_pulse_seen", seen, 1);
        chk("t2_latency", n, DB + 3);
        repeat (40) @(negedge clk);
        btn_insert_raw = 1'b1;
        repeat (DB + 10) @(negedge clk);
        chk("t2_ins_pulses", ins_cnt, 1);
        chk("t2_num", num, 5);
        chk("t2_count", digit_count, 1);

        // T3: glitch one cycle short of the debounce window
        ins_cnt = 0;
        btn_insert_raw = 1'b0;
        repeat (DB - 1) @(negedge clk);
        btn_insert_raw = 1'b1;
        repeat (DB + 10) @(negedge clk);
        chk("t3_glitch_pulses", ins_cnt, 0);
        chk("t3_count", digit_count, 1);

        // Table of clean presses
        for (int i = 0; i < 15; i++) begin
            press(vt[i].ins, vt[i].fin, vt[i].sw);
            chk($sformatf("v%0d_insert_pulses", i), ins_cnt, vt[i].exp_ins);
            chk($sformatf("v%0d_finish_pulses", i), fin_cnt, vt[i].exp_fin);
            chk($sformatf("v%0d_num", i), num, vt[i].exp_num);
            chk($sformatf("v%0d_digit_err", i), digit_err, vt[i].exp_err);
            chk($sformatf("v%0d_digit_count", i), digit_count, vt[i].exp_cnt);
        end
        chk("never_both_high", both_high, 0);

        // T6: reset mid-debounce discards progress
        sw_num = 4'd3;
        repeat (4) @(negedge clk);
        btn_insert_raw = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        btn_insert_raw = 1'b1;
        #1;
        chk("midreset_num", num, 0);
        chk("midreset_count", digit_count, 0);
        @(negedge clk);
        reset = 1'b1;
        ins_cnt = 0;
        fin_cnt = 0;
        repeat (DB + 20) @(negedge clk);
        chk("midreset_no_pulse", ins_cnt + fin_cnt, 0);
        chk("midreset_num_after", num, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
